// File: rtl/spi_cmd_ctrl_if.sv
// SPI command-controller bus: frame/byte events from the SPI datapath and register-side outputs.
// The slave modport is the controller; the master modport drives frames and observes results.
interface spi_cmd_ctrl_if;
    logic       SSEL_ACTIVE;
    logic       SSEL_START;
    logic       RX_VALID;
    logic [7:0] RX_BYTE;
    logic [6:0] STATUS_IN;
    logic [7:0] TX_BYTE;
    logic [7:0] REG0;
    logic [7:0] REG1;
    logic [7:0] REG2;
    logic       WR_STROBE;
    logic [1:0] WR_ADDR;
    logic       ERR;

    modport slave (
        input  SSEL_ACTIVE, SSEL_START, RX_VALID, RX_BYTE, STATUS_IN,
        output TX_BYTE, REG0, REG1, REG2, WR_STROBE, WR_ADDR, ERR
    );

    modport master (
        output SSEL_ACTIVE, SSEL_START, RX_VALID, RX_BYTE, STATUS_IN,
        input  TX_BYTE, REG0, REG1, REG2, WR_STROBE, WR_ADDR, ERR
    );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// SPI slave command decoder: command byte selects read/write and start address, then bytes stream in/out.
// All outputs registered; TX_BYTE updates exactly 1 cycle after RX_VALID; no backpressure, every byte is consumed.
module spi_cmd_ctrl (
    input  logic           CLK,
    input  logic           RST_N,
    spi_cmd_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] addr;
    logic [1:0] addr_nxt;
    logic [7:0] tx_nxt;
    logic       wr_en;
    logic       err_set;
    logic [1:0] rd_sel;
    logic [7:0] rd_data;

    // Read source: the command byte's address on the command cycle, the running pointer afterwards.
    always_comb begin
        rd_sel = (state == CMD) ? bus.RX_BYTE[1:0] : addr;
        case (rd_sel)
            2'd0:    rd_data = bus.REG0;
            2'd1:    rd_data = bus.REG1;
            2'd2:    rd_data = bus.REG2;
            default: rd_data = {bus.ERR, bus.STATUS_IN};
        endcase
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        tx_nxt    = bus.TX_BYTE;
        wr_en     = 1'b0;
        err_set   = 1'b0;
        if (!bus.SSEL_ACTIVE) begin
            state_nxt = IDLE;
            addr_nxt  = 2'd0;
        end else if (bus.SSEL_START) begin
            // A byte arriving with the frame start belongs to no command and is dropped.
            state_nxt = CMD;
            addr_nxt  = 2'd0;
            tx_nxt    = 8'hA5;
        end else if (bus.RX_VALID) begin
            case (state)
                CMD: begin
                    if (bus.RX_BYTE[7]) begin
                        state_nxt = WRITE;
                        addr_nxt  = bus.RX_BYTE[1:0];
                    end else begin
                        state_nxt = READ;
                        addr_nxt  = bus.RX_BYTE[1:0] + 2'd1;
                        tx_nxt    = rd_data;
                    end
                end
                WRITE: begin
                    if (addr == 2'd3) begin
                        err_set = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                    end
                    tx_nxt   = 8'h5A;
                    addr_nxt = addr + 2'd1;
                end
                READ: begin
                    tx_nxt   = rd_data;
                    addr_nxt = addr + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
            addr  <= 2'd0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            bus.TX_BYTE   <= 8'h00;
            bus.REG0      <= 8'h00;
            bus.REG1      <= 8'h00;
            bus.REG2      <= 8'h00;
            bus.WR_STROBE <= 1'b0;
            bus.WR_ADDR   <= 2'd0;
            bus.ERR       <= 1'b0;
        end else begin
            bus.TX_BYTE   <= tx_nxt;
            bus.WR_STROBE <= wr_en;
            if (err_set) begin
                bus.ERR <= 1'b1;
            end
            if (wr_en) begin
                bus.WR_ADDR <= addr;
                case (addr)
                    2'd0:    bus.REG0 <= bus.RX_BYTE;
                    2'd1:    bus.REG1 <= bus.RX_BYTE;
                    default: bus.REG2 <= bus.RX_BYTE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Bench for spi_cmd_ctrl: directed vector table, hand sequences for sticky error and reset mid-frame,
// then randomized frames compared against a frame-level behavioural model.
module tb_spi_cmd_ctrl;
    logic CLK = 1'b0;
    logic RST_N;
    spi_cmd_ctrl_if bus ();

    spi_cmd_ctrl dut (.CLK(CLK), .RST_N(RST_N), .bus(bus.slave));

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst_n;
        logic       act;
        logic       start;
        logic       vld;
        logic [7:0] rxb;
        logic [6:0] status;
        logic [7:0] tx;
        logic [7:0] r0;
        logic [7:0] r1;
        logic [7:0] r2;
        logic       stb;
        logic [1:0] wa;
        logic       err;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   failures = 0;

    // Frame-level model: registers as an array, a pointer that wraps mod 4, and frame/command flags.
    logic [7:0] m_reg [3];
    logic [7:0] m_tx;
    logic       m_stb;
    logic [1:0] m_wa;
    logic       m_err;
    bit         m_in_frame;
    bit         m_need_cmd;
    bit         m_is_write;
    int         m_ptr;

    function automatic logic [7:0] m_read(int p, logic [6:0] st);
        return (p < 3) ? m_reg[p] : {m_err, st};
    endfunction

    task automatic model_step(input logic rst, input logic a, input logic s, input logic v,
                              input logic [7:0] b, input logic [6:0] st);
        if (!rst) begin
            foreach (m_reg[k]) m_reg[k] = 8'h00;
            m_tx = 8'h00; m_stb = 1'b0; m_wa = 2'd0; m_err = 1'b0;
            m_in_frame = 0; m_need_cmd = 0; m_is_write = 0; m_ptr = 0;
        end else begin
            m_stb = 1'b0;
            if (!a) begin
                m_in_frame = 0;
            end else if (s) begin
                m_in_frame = 1; m_need_cmd = 1; m_tx = 8'hA5;
            end else if (v && m_in_frame) begin
                if (m_need_cmd) begin
                    m_need_cmd = 0;
                    m_is_write = b[7];
                    m_ptr = int'(b[1:0]);
                    if (!m_is_write) begin
                        m_tx = m_read(m_ptr, st);
                        m_ptr = (m_ptr + 1) % 4;
                    end
                end else if (m_is_write) begin
                    if (m_ptr == 3) m_err = 1'b1;
                    else begin
                        m_reg[m_ptr] = b; m_stb = 1'b1; m_wa = 2'(m_ptr);
                    end
                    m_tx = 8'h5A;
                    m_ptr = (m_ptr + 1) % 4;
                end else begin
                    m_tx = m_read(m_ptr, st);
                    m_ptr = (m_ptr + 1) % 4;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, got, want);
        end
    endtask

    task automatic step(input logic rst, input logic a, input logic s, input logic v,
                        input logic [7:0] b, input logic [6:0] st);
        @(negedge CLK);
        RST_N = rst;
        bus.SSEL_ACTIVE = a; bus.SSEL_START = s; bus.RX_VALID = v;
        bus.RX_BYTE = b; bus.STATUS_IN = st;
        @(posedge CLK);
        #1;
        model_step(rst, a, s, v, b, st);
    endtask

    task automatic add(input logic rst, input logic a, input logic s, input logic v,
                       input logic [7:0] b, input logic [6:0] st, input logic [7:0] tx,
                       input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2,
                       input logic stb, input logic [1:0] wa, input logic err);
        vec_t e;
        e.rst_n = rst; e.act = a; e.start = s; e.vld = v; e.rxb = b; e.status = st;
        e.tx = tx; e.r0 = r0; e.r1 = r1; e.r2 = r2; e.stb = stb; e.wa = wa; e.err = err;
        vecs.push_back(e);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " tx"},  bus.TX_BYTE, m_tx);
        chk({tag, " r0"},  bus.REG0, m_reg[0]);
        chk({tag, " r1"},  bus.REG1, m_reg[1]);
        chk({tag, " r2"},  bus.REG2, m_reg[2]);
        chk({tag, " stb"}, {7'd0, bus.WR_STROBE}, {7'd0, m_stb});
        chk({tag, " wa"},  {6'd0, bus.WR_ADDR}, {6'd0, m_wa});
        chk({tag, " err"}, {7'd0, bus.ERR}, {7'd0, m_err});
    endtask

    initial begin
        RST_N = 1'b0;
        bus.SSEL_ACTIVE = 1'b0; bus.SSEL_START = 1'b0; bus.RX_VALID = 1'b0;
        bus.RX_BYTE = 8'h00; bus.STATUS_IN = 7'h00;

        //  rst act st vld byte  stat   tx    r0    r1    r2   stb wa err
        add(0, 0, 0, 0, 8'h00, 7'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        // write burst to 1,2
        add(1, 1, 1, 0, 8'h00, 7'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        add(1, 1, 0, 1, 8'h81, 7'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        add(1, 1, 0, 1, 8'h11, 7'h00, 8'h5A, 8'h00, 8'h11, 8'h00, 1, 1, 0);
        add(1, 1, 0, 0, 8'h00, 7'h00, 8'h5A, 8'h00, 8'h11, 8'h00, 0, 1, 0);
        add(1, 1, 0, 1, 8'h22, 7'h00, 8'h5A, 8'h00, 8'h11, 8'h22, 1, 2, 0);
        add(1, 0, 0, 0, 8'h00, 7'h00, 8'h5A, 8'h00, 8'h11, 8'h22, 0, 2, 0);
        // wrap through read-only address 3
        add(1, 1, 1, 0, 8'h00, 7'h00, 8'hA5, 8'h00, 8'h11, 8'h22, 0, 2, 0);
        add(1, 1, 0, 1, 8'h82, 7'h00, 8'hA5, 8'h00, 8'h11, 8'h22, 0, 2, 0);
        add(1, 1, 0, 1, 8'hAA, 7'h00, 8'h5A, 8'h00, 8'h11, 8'hAA, 1, 2, 0);
        add(1, 1, 0, 1, 8'hBB, 7'h00, 8'h5A, 8'h00, 8'h11, 8'hAA, 0, 2, 1);
        add(1, 1, 0, 1, 8'hCC, 7'h00, 8'h5A, 8'hCC, 8'h11, 8'hAA, 1, 0, 1);
        add(1, 0, 0, 0, 8'h00, 7'h00, 8'h5A, 8'hCC, 8'h11, 8'hAA, 0, 0, 1);
        // reset with coincident start/byte, then byte while idle
        add(0, 1, 1, 1, 8'h81, 7'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        add(1, 1, 0, 1, 8'h81, 7'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        // load REG0/REG1 for the read test
        add(1, 1, 1, 0, 8'h00, 7'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        add(1, 1, 0, 1, 8'h80, 7'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        add(1, 1, 0, 1, 8'h10, 7'h00, 8'h5A, 8'h10, 8'h00, 8'h00, 1, 0, 0);
        add(1, 1, 0, 1, 8'h20, 7'h00, 8'h5A, 8'h10, 8'h20, 8'h00, 1, 1, 0);
        add(1, 0, 0, 0, 8'h00, 7'h00, 8'h5A, 8'h10, 8'h20, 8'h00, 0, 1, 0);
        // read burst from 0 with status 0x05
        add(1, 1, 1, 0, 8'h00, 7'h05, 8'hA5, 8'h10, 8'h20, 8'h00, 0, 1, 0);
        add(1, 1, 0, 1, 8'h00, 7'h05, 8'h10, 8'h10, 8'h20, 8'h00, 0, 1, 0);
        add(1, 1, 0, 1, 8'hFF, 7'h05, 8'h20, 8'h10, 8'h20, 8'h00, 0, 1, 0);
        add(1, 1, 0, 1, 8'hFF, 7'h05, 8'h00, 8'h10, 8'h20, 8'h00, 0, 1, 0);
        add(1, 1, 0, 1, 8'hFF, 7'h05, 8'h05, 8'h10, 8'h20, 8'h00, 0, 1, 0);
        add(1, 0, 0, 0, 8'h00, 7'h05, 8'h05, 8'h10, 8'h20, 8'h00, 0, 1, 0);
        // abort after write command; next frame's 0x55 is a read of addr 1
        add(1, 1, 1, 0, 8'h00, 7'h00, 8'hA5, 8'h10, 8'h20, 8'h00, 0, 1, 0);
        add(1, 1, 0, 1, 8'h80, 7'h00, 8'hA5, 8'h10, 8'h20, 8'h00, 0, 1, 0);
        add(1, 0, 0, 0, 8'h00, 7'h00, 8'hA5, 8'h10, 8'h20, 8'h00, 0, 1, 0);
        add(1, 0, 0, 1, 8'h33, 7'h00, 8'hA5, 8'h10, 8'h20, 8'h00, 0, 1, 0);
        add(1, 1, 1, 0, 8'h00, 7'h00, 8'hA5, 8'h10, 8'h20, 8'h00, 0, 1, 0);
        add(1, 1, 0, 1, 8'h55, 7'h00, 8'h20, 8'h10, 8'h20, 8'h00, 0, 1, 0);
        add(1, 0, 0, 0, 8'h00, 7'h00, 8'h20, 8'h10, 8'h20, 8'h00, 0, 1, 0);
        // start/byte collision: byte dropped, following 0x02 is the read command
        add(1, 1, 1, 1, 8'h81, 7'h00, 8'hA5, 8'h10, 8'h20, 8'h00, 0, 1, 0);
        add(1, 1, 0, 1, 8'h02, 7'h00, 8'h00, 8'h10, 8'h20, 8'h00, 0, 1, 0);
        add(1, 0, 0, 0, 8'h00, 7'h00, 8'h00, 8'h10, 8'h20, 8'h00, 0, 1, 0);
        add(1, 1, 0, 1, 8'h81, 7'h00, 8'h00, 8'h10, 8'h20, 8'h00, 0, 1, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].act, vecs[i].start, vecs[i].vld, vecs[i].rxb, vecs[i].status);
            chk($sformatf("row%0d tx", i),  bus.TX_BYTE, vecs[i].tx);
            chk($sformatf("row%0d r0", i),  bus.REG0, vecs[i].r0);
            chk($sformatf("row%0d r1", i),  bus.REG1, vecs[i].r1);
            chk($sformatf("row%0d r2", i),  bus.REG2, vecs[i].r2);
            chk($sformatf("row%0d stb", i), {7'd0, bus.WR_STROBE}, {7'd0, vecs[i].stb});
            chk($sformatf("row%0d wa", i),  {6'd0, bus.WR_ADDR}, {6'd0, vecs[i].wa});
            chk($sformatf("row%0d err", i), {7'd0, bus.ERR}, {7'd0, vecs[i].err});
        end

        // Sticky error and read of address 3 with ERR set.
        step(1, 1, 1, 0, 8'h00, 7'h00);
        step(1, 1, 0, 1, 8'h83, 7'h00);
        step(1, 1, 0, 1, 8'h01, 7'h00);
        chk("ro write err", {7'd0, bus.ERR}, 8'h01);
        chk("ro write nostb", {7'd0, bus.WR_STROBE}, 8'h00);
        step(1, 1, 0, 1, 8'h02, 7'h00);
        chk("wrap to reg0", bus.REG0, 8'h02);
        chk("wrap wr_addr", {6'd0, bus.WR_ADDR}, 8'h00);
        step(1, 1, 1, 0, 8'h00, 7'h00);
        step(1, 1, 0, 1, 8'h83, 7'h00);
        step(1, 1, 0, 1, 8'h09, 7'h00);
        chk("err sticky", {7'd0, bus.ERR}, 8'h01);
        step(1, 1, 1, 0, 8'h00, 7'h7F);
        step(1, 1, 0, 1, 8'h03, 7'h7F);
        chk("read addr3", bus.TX_BYTE, 8'hFF);
        step(1, 1, 0, 1, 8'h00, 7'h7F);
        chk("read wrap reg0", bus.TX_BYTE, 8'h02);
        step(1, 0, 0, 0, 8'h00, 7'h00);

        // Reset during a write burst.
        step(1, 1, 1, 0, 8'h00, 7'h00);
        step(1, 1, 0, 1, 8'h80, 7'h00);
        step(1, 1, 0, 1, 8'h77, 7'h00);
        chk("pre-reset reg0", bus.REG0, 8'h77);
        step(0, 1, 0, 1, 8'h99, 7'h00);
        chk("rst tx", bus.TX_BYTE, 8'h00);
        chk("rst reg0", bus.REG0, 8'h00);
        chk("rst err", {7'd0, bus.ERR}, 8'h00);
        chk("rst stb", {7'd0, bus.WR_STROBE}, 8'h00);
        step(1, 1, 0, 1, 8'h44, 7'h00);
        step(1, 1, 0, 1, 8'h45, 7'h00);
        chk("post-rst ignore reg0", bus.REG0, 8'h00);
        chk("post-rst ignore stb", {7'd0, bus.WR_STROBE}, 8'h00);
        chk("post-rst ignore tx", bus.TX_BYTE, 8'h00);
        step(1, 1, 1, 0, 8'h00, 7'h00);
        chk("post-rst start tx", bus.TX_BYTE, 8'hA5);

        // Randomized frames against the model.
        for (int n = 0; n < 3000; n++) begin
            logic r, a, s, v;
            r = ($urandom_range(0, 149) != 0);
            a = ($urandom_range(0, 39) != 0);
            s = ($urandom_range(0, 24) == 0);
            v = ($urandom_range(0, 2) == 0);
            step(r, a, s, v, 8'($urandom), 7'($urandom));
            chk_model($sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_cmd_ctrl.md
SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

Interface
REQ-001 Port CLK, input, 1 bit: single clock; all logic SHALL be rising-edge CLK.
REQ-002 Port RST_N, input, 1 bit: reset, synchronous and active-low.
REQ-003 Port SSEL_ACTIVE, input, 1 bit: high while the SPI frame is selected. Already synchronised.
REQ-004 Port SSEL_START, input, 1 bit: 1-cycle pulse at frame start.
REQ-005 Port RX_VALID, input, 1 bit: 1-cycle pulse; RX_BYTE holds a complete received byte.
REQ-006 Port RX_BYTE, input, 8 bits: received byte, MSB-first assembled.
REQ-007 Port STATUS_IN, input, 7 bits: live status, readable at address 3.
REQ-008 Port TX_BYTE, output, 8 bits: byte the SPI datapath loads for the next transmit slot.
REQ-009 Port REG0 / REG1 / REG2, output, 8 bits each: writable control registers.
REQ-010 Port WR_STROBE, output, 1 bit: 1-cycle pulse per accepted register write.
REQ-011 Port WR_ADDR, output, 2 bits: address of the current WR_STROBE.
REQ-012 Port ERR, output, 1 bit: sticky protocol-error flag.
REQ-013 No parameters; register count fixed at 4 addresses (0-2 R/W, 3 read-only).

Function
REQ-014 The FSM SHALL have states IDLE, CMD, WRITE, READ; all outputs registered.
REQ-015 IDLE->CMD on SSEL_START; any state->IDLE when SSEL_ACTIVE=0 (takes priority over all else).
REQ-016 In CMD, first RX_VALID is the command: bit7=1 -> WRITE, bit7=0 -> READ; ADDR<=bits[1:0]; bits[6:2] ignored.
REQ-017 SSEL_START in any state SHALL restart in CMD and reload TX_BYTE=8'hA5 (sync byte); an RX_VALID in the same cycle SHALL be dropped.
REQ-018 WRITE: each RX_VALID writes RX_BYTE to register ADDR the next cycle.
  - On that cycle: WR_STROBE=1, WR_ADDR=ADDR.
  - ADDR then increments modulo 4.
REQ-019 WRITE to ADDR=3: no register change, no WR_STROBE, ERR<=1; ADDR still increments (3->0).
REQ-020 On entry to READ, TX_BYTE SHALL be loaded with data(ADDR) the cycle after the command RX_VALID.
  - ADDR then increments modulo 4.
  - Each further RX_VALID (dummy byte) loads data(ADDR) the following cycle and increments again.
REQ-021 data(0..2)=REGn; data(3)={ERR, STATUS_IN}, sampled at the load cycle.
REQ-022 In WRITE, TX_BYTE SHALL be loaded with 8'h5A the cycle after each RX_VALID (write acknowledge).
REQ-023 TX_BYTE latency SHALL be exactly 1 CLK after RX_VALID.
  - Outside load events, TX_BYTE holds its value.
REQ-024 RX_VALID while in IDLE or while SSEL_ACTIVE=0 SHALL be ignored.
REQ-025 Frame end mid-byte: no partial effect.
  - Writes already strobed remain.
  - ADDR is discarded; the next frame requires a new command.
REQ-026 ERR clears only on reset.
  - A write to address 3 with ERR already set keeps ERR=1.

Reset
REQ-027 When RST_N=0 at a CLK edge, the following SHALL hold the next cycle, regardless of frame activity:
  - state=IDLE, ADDR=0
  - REG0=REG1=REG2=8'h00, TX_BYTE=8'h00
  - WR_STROBE=0, WR_ADDR=0, ERR=0
REQ-028 RX_VALID/SSEL_START coincident with RST_N=0 SHALL be ignored.

Verification
REQ-029 Write burst: START, bytes 0x81,0x11,0x22 -> REG1=0x11, REG2=0x22.
  - WR_STROBE pulses with WR_ADDR=1 then 2.
  - TX_BYTE=0x5A after each data byte; ERR=0.
REQ-030 Wrap: write burst 0x82,0xAA,0xBB,0xCC -> REG2=0xAA, REG0=0xCC; ERR=1 (addr 3 skipped, no strobe).
REQ-031 Read: REG0=0x10, REG1=0x20, STATUS_IN=0x05, ERR=0; frame 0x00 then 3 dummies -> TX_BYTE sequence:
  - 0xA5 at start
  - 0x10 one cycle after cmd
  - then 0x20, REG2, 0x05
REQ-032 Abort: SSEL_ACTIVE drops after cmd 0x80 before data; next frame sends 0x55 as first byte -> treated as READ cmd, addr 1, no write.
REQ-033 Reset mid-frame: RST_N=0 one cycle during WRITE -> all outputs at REQ-027 values; subsequent RX_VALID ignored until SSEL_START.
REQ-034 Collision: SSEL_START and RX_VALID same cycle -> byte dropped, TX_BYTE=0xA5, state CMD.
